// File: rtl/popcount_ctrl_if.sv
// Word-stream bundle (data, byte keep, last, valid/ready) shared by the upstream
// and engine-side ports of popcount_ctrl.
interface popcount_ctrl_if;
  logic [31:0] TDATA;
  logic [3:0]  TKEEP;
  logic        TLAST;
  logic        TVALID;
  logic        TREADY;

  modport master (output TDATA, output TKEEP, output TLAST, output TVALID, input TREADY);
  modport slave  (input TDATA, input TKEEP, input TLAST, input TVALID, output TREADY);
endinterface

// File: rtl/popcount_ctrl.sv
// Job controller for a popcount engine: clears the engine, gates a fixed-length
// word stream through to it, then captures the engine total as RESULT.
module popcount_ctrl #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             S_AXIS_ACLK,
  input  logic             S_AXIS_ARESET,
  popcount_ctrl_if.slave   S_AXIS,
  popcount_ctrl_if.master  M_AXIS,
  input  logic [LEN_W-1:0] CFG_LEN,
  input  logic             CFG_START,
  input  logic             CFG_ABORT,
  output logic             ENG_COUNT_RST,
  input  logic [31:0]      ENG_COUNT,
  input  logic             ENG_COUNT_BUSY,
  output logic [31:0]      RESULT,
  output logic [LEN_W-1:0] WORDS_LEFT,
  output logic             BUSY,
  output logic             DONE,
  output logic             DONE_PULSE,
  output logic             ERR_LEN
);

  typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, FINISH} state_t;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] words_nxt;
  logic [31:0]      result_nxt;
  logic             done_nxt, err_nxt;
  logic             drain_wait, drain_wait_nxt;
  logic             eng_clr_q, eng_clr_nxt;
  logic             streaming, beat, last_word;

  assign streaming = (state == STREAM);
  assign beat      = streaming && S_AXIS.TVALID && M_AXIS.TREADY;
  assign last_word = (WORDS_LEFT == LEN_W'(1));

  assign M_AXIS.TDATA  = S_AXIS.TDATA;
  assign M_AXIS.TKEEP  = S_AXIS.TKEEP;
  assign M_AXIS.TVALID = streaming && S_AXIS.TVALID;
  assign M_AXIS.TLAST  = streaming && last_word;
  assign S_AXIS.TREADY = streaming && M_AXIS.TREADY;

  assign BUSY          = (state != IDLE);
  // An abort arriving in FINISH cancels the completion strobe as well as DONE.
  assign DONE_PULSE    = (state == FINISH) && !CFG_ABORT;
  assign ENG_COUNT_RST = eng_clr_q || (state == CLEAR);

  always_comb begin
    state_nxt      = state;
    words_nxt      = WORDS_LEFT;
    result_nxt     = RESULT;
    done_nxt       = DONE;
    err_nxt        = ERR_LEN;
    drain_wait_nxt = drain_wait;
    eng_clr_nxt    = 1'b0;
    if (CFG_ABORT && state != IDLE) begin
      state_nxt      = IDLE;
      words_nxt      = '0;
      eng_clr_nxt    = 1'b1;
      drain_wait_nxt = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (CFG_START) begin
            done_nxt = 1'b0;
            err_nxt  = 1'b0;
            if (CFG_LEN == '0) begin
              state_nxt  = FINISH;
              result_nxt = '0;
            end else begin
              state_nxt = CLEAR;
              words_nxt = CFG_LEN;
            end
          end
        end
        CLEAR: state_nxt = STREAM;
        STREAM: begin
          if (beat) begin
            if (WORDS_LEFT != '0) words_nxt = WORDS_LEFT - LEN_W'(1);
            if (last_word || S_AXIS.TLAST) begin
              state_nxt      = DRAIN;
              drain_wait_nxt = 1'b0;
            end
            if (last_word != S_AXIS.TLAST) err_nxt = 1'b1;
          end
        end
        DRAIN: begin
          // First DRAIN cycle only arms the wait; exit is considered from the second on.
          if (!drain_wait) begin
            drain_wait_nxt = 1'b1;
          end else if (!ENG_COUNT_BUSY) begin
            result_nxt = ENG_COUNT;
            state_nxt  = FINISH;
          end
        end
        FINISH: begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXIS_ACLK) begin
    if (S_AXIS_ARESET) begin
      state      <= IDLE;
      WORDS_LEFT <= '0;
      RESULT     <= '0;
      DONE       <= 1'b0;
      ERR_LEN    <= 1'b0;
      drain_wait <= 1'b0;
      eng_clr_q  <= 1'b1;
    end else begin
      state      <= state_nxt;
      WORDS_LEFT <= words_nxt;
      RESULT     <= result_nxt;
      DONE       <= done_nxt;
      ERR_LEN    <= err_nxt;
      drain_wait <= drain_wait_nxt;
      eng_clr_q  <= eng_clr_nxt;
    end
  end

endmodule
